op_sequencer: RTL and testbench

Command-sequencing stage directly upstream of the combinational `operator` unit. Accepts operator commands (opcode plus operands) over a valid/ready handshake and buffers them in a small FIFO. Issues one command at a time to `operator` through registered operand outputs, captures `Y`/`R`/`A` one cycle later, and presents the tagged result downstream over a second valid/ready handshake. Replaces the free-running opcode stepping currently done by hand in benches with a clocked, back-pressured issue path.

---
 rtl/op_pkg.sv | 38 +++
 rtl/op_cmd_fifo.sv | 53 +++++
 rtl/op_sequencer.sv | 128 ++++++++++++
 tb/tb_op_sequencer.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/op_pkg.sv
// Shared types and constants for the operator command sequencer.
// Opcodes above OP_LAST are issued anyway but report an error result.
package op_pkg;

    localparam int OP_W  = 5;
    localparam int CMD_W = 13;

    localparam logic [OP_W-1:0] OP_LAST = 5'd22;

    // Base code of each opcode group; a group runs up to the next base.
    localparam logic [OP_W-1:0] OP_ARITH_BASE   = 5'd0;
    localparam logic [OP_W-1:0] OP_BITWISE_BASE = 5'd5;
    localparam logic [OP_W-1:0] OP_SHIFT_BASE   = 5'd9;
    localparam logic [OP_W-1:0] OP_CMP_BASE     = 5'd11;
    localparam logic [OP_W-1:0] OP_LOGIC_BASE   = 5'd17;
    localparam logic [OP_W-1:0] OP_COND_BASE    = 5'd19;
    localparam logic [OP_W-1:0] OP_REDUCE_BASE  = 5'd20;
    localparam logic [OP_W-1:0] OP_CONCAT_BASE  = 5'd22;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        HOLD = 2'd2
    } seq_state_t;

    typedef struct packed {
        logic [OP_W-1:0] opcode;
        logic            a;
        logic            b;
        logic [2:0]      c;
        logic [2:0]      d;
    } cmd_t;

    function automatic logic op_illegal(input logic [OP_W-1:0] op);
        return op > OP_LAST;
    endfunction

endpackage

// File: rtl/op_cmd_fifo.sv
// Synchronous command FIFO; DEPTH must be a power of two so pointers wrap
// naturally.
module op_cmd_fifo
    import op_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = CMD_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [W-1:0]             wr_data,
    input  logic                     pop,
    output logic [W-1:0]             rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    assign rd_data = mem[rd_ptr];
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/op_sequencer.sv
// Buffers operator commands, issues them one at a time to the combinational
// operator unit and holds each tagged result until downstream accepts it.
//
//   state | meaning
//   IDLE  | no command in flight; load from FIFO head when non-empty
//   EXEC  | operands registered, operator settling; capture at next edge
//   HOLD  | result presented with res_valid=1 until res_ready
module op_sequencer
    import op_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [OP_W-1:0] cmd_opcode,
    input  logic            cmd_a,
    input  logic            cmd_b,
    input  logic [2:0]      cmd_c,
    input  logic [2:0]      cmd_d,
    output logic [OP_W-1:0] opocode,
    output logic            a,
    output logic            b,
    output logic [2:0]      c,
    output logic [2:0]      d,
    input  logic            Y,
    input  logic [5:0]      R,
    input  logic [2:0]      A,
    output logic            res_valid,
    input  logic            res_ready,
    output logic [OP_W-1:0] res_opcode,
    output logic            res_y,
    output logic [5:0]      res_r,
    output logic [2:0]      res_a,
    output logic            res_err,
    output logic            busy
);

    seq_state_t              state;
    cmd_t                    head;
    logic [CMD_W-1:0]        fifo_rd;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic [$clog2(DEPTH):0]  fifo_count;
    logic                    push;
    logic                    pop;
    logic                    exec_err;

    assign cmd_ready = !fifo_full;
    assign push      = cmd_valid && !fifo_full;
    // A load happens from IDLE or on the HOLD handshake; both consume the head.
    assign pop       = !fifo_empty && ((state == IDLE) || (state == HOLD && res_ready));
    assign head      = cmd_t'(fifo_rd);
    assign exec_err  = op_illegal(opocode);
    assign busy      = (state != IDLE) || (fifo_count != '0);

    op_cmd_fifo #(
        .DEPTH (DEPTH),
        .W     (CMD_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .wr_data ({cmd_opcode, cmd_a, cmd_b, cmd_c, cmd_d}),
        .pop     (pop),
        .rd_data (fifo_rd),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            opocode    <= '0;
            a          <= 1'b0;
            b          <= 1'b0;
            c          <= '0;
            d          <= '0;
            res_valid  <= 1'b0;
            res_opcode <= '0;
            res_y      <= 1'b0;
            res_r      <= '0;
            res_a      <= '0;
            res_err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        opocode <= head.opcode;
                        a       <= head.a;
                        b       <= head.b;
                        c       <= head.c;
                        d       <= head.d;
                        state   <= EXEC;
                    end
                end
                EXEC: begin
                    res_opcode <= opocode;
                    res_err    <= exec_err;
                    res_y      <= exec_err ? 1'b0 : Y;
                    res_r      <= exec_err ? 6'd0 : R;
                    res_a      <= exec_err ? 3'd0 : A;
                    res_valid  <= 1'b1;
                    state      <= HOLD;
                end
                HOLD: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        if (pop) begin
                            opocode <= head.opcode;
                            a       <= head.a;
                            b       <= head.b;
                            c       <= head.c;
                            d       <= head.d;
                            state   <= EXEC;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_op_sequencer.sv
// Directed bench for op_sequencer with a behavioural operator stub:
// R = {c,d} ^ r_noise, Y = a ^ b, A = c & d.
module tb_op_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [4:0] cmd_opcode;
    logic       cmd_a, cmd_b;
    logic [2:0] cmd_c, cmd_d;
    logic [4:0] opocode;
    logic       a, b;
    logic [2:0] c, d;
    logic       op_y;
    logic [5:0] op_r;
    logic [2:0] op_a;
    logic [5:0] r_noise;
    logic       res_valid;
    logic       res_ready;
    logic [4:0] res_opcode;
    logic       res_y;
    logic [5:0] res_r;
    logic [2:0] res_a;
    logic       res_err;
    logic       busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign op_r = {c, d} ^ r_noise;
    assign op_y = a ^ b;
    assign op_a = c & d;

    op_sequencer #(.DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_opcode (cmd_opcode),
        .cmd_a      (cmd_a),
        .cmd_b      (cmd_b),
        .cmd_c      (cmd_c),
        .cmd_d      (cmd_d),
        .opocode    (opocode),
        .a          (a),
        .b          (b),
        .c          (c),
        .d          (d),
        .Y          (op_y),
        .R          (op_r),
        .A          (op_a),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_opcode (res_opcode),
        .res_y      (res_y),
        .res_r      (res_r),
        .res_a      (res_a),
        .res_err    (res_err),
        .busy       (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [4:0] op, input logic ai, input logic bi,
                         input logic [2:0] ci, input logic [2:0] di);
        cmd_opcode = op;
        cmd_a      = ai;
        cmd_b      = bi;
        cmd_c      = ci;
        cmd_d      = di;
        cmd_valid  = 1'b1;
    endtask

    initial begin
        rst        = 1'b1;
        cmd_valid  = 1'b0;
        cmd_opcode = '0;
        cmd_a      = 1'b0;
        cmd_b      = 1'b0;
        cmd_c      = '0;
        cmd_d      = '0;
        res_ready  = 1'b0;
        r_noise    = '0;
        tick();
        tick();
        rst = 1'b0;

        chk("rst_res_valid", res_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_opocode", opocode, 0);
        chk("rst_res_r", res_r, 0);

        // single command latency
        drive(5'd0, 1'b1, 1'b0, 3'b101, 3'b001);
        tick();
        cmd_valid = 1'b0;
        chk("lat_n_valid", res_valid, 0);
        chk("lat_n_busy", busy, 1);
        tick();
        chk("lat_n1_valid", res_valid, 0);
        chk("lat_n1_a", a, 1);
        chk("lat_n1_c", c, 3'b101);
        chk("lat_n1_d", d, 3'b001);
        tick();
        chk("lat_n2_valid", res_valid, 1);
        chk("lat_n2_r", res_r, 6'b101001);
        chk("lat_n2_y", res_y, 1);
        chk("lat_n2_a", res_a, 3'b001);
        chk("lat_n2_err", res_err, 0);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk("lat_done_valid", res_valid, 0);
        chk("lat_done_busy", busy, 0);

        // illegal opcode followed by legal top opcode
        drive(5'b11000, 1'b1, 1'b1, 3'b111, 3'b111);
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        chk("ill_valid", res_valid, 1);
        chk("ill_err", res_err, 1);
        chk("ill_r", res_r, 0);
        chk("ill_y", res_y, 0);
        chk("ill_a", res_a, 0);
        chk("ill_opcode", res_opcode, 5'b11000);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        drive(5'b10110, 1'b1, 1'b0, 3'b011, 3'b110);
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        chk("leg_valid", res_valid, 1);
        chk("leg_err", res_err, 0);
        chk("leg_opcode", res_opcode, 5'b10110);
        chk("leg_r", res_r, 6'b011110);
        chk("leg_a", res_a, 3'b010);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;

        // hold under stall with a second command queued
        drive(5'd5, 1'b0, 1'b1, 3'b010, 3'b100);
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        chk("hold_start_valid", res_valid, 1);
        for (int i = 0; i < 7; i++) begin
            r_noise = 6'(i + 1);
            if (i == 0) drive(5'd7, 1'b1, 1'b1, 3'b001, 3'b010);
            tick();
            cmd_valid = 1'b0;
            chk("hold_valid", res_valid, 1);
            chk("hold_r", res_r, 6'b010100);
            chk("hold_y", res_y, 1);
            chk("hold_opcode", res_opcode, 5'd5);
        end
        r_noise   = '0;
        res_ready = 1'b1;
        tick();
        chk("hold_hs_valid", res_valid, 0);
        chk("hold_hs_opocode", opocode, 5'd7);
        tick();
        chk("hold_next_valid", res_valid, 1);
        chk("hold_next_opcode", res_opcode, 5'd7);
        chk("hold_next_r", res_r, 6'b001010);
        tick();
        res_ready = 1'b0;
        chk("hold_drain_valid", res_valid, 0);

        // fill FIFO under back-pressure
        for (int k = 0; k < 6; k++) begin
            drive(5'(k + 1), 1'b1, 1'b1, 3'(k), 3'(k + 2));
            chk("fill_cmd_ready", cmd_ready, (k < 5) ? 1 : 0);
            tick();
        end
        cmd_valid = 1'b0;
        chk("fill_full_ready", cmd_ready, 0);
        chk("fill_busy", busy, 1);
        res_ready = 1'b1;
        for (int j = 0; j < 5; j++) begin
            chk("fill_res_valid", res_valid, 1);
            chk("fill_res_opcode", res_opcode, 5'(j + 1));
            chk("fill_res_r", res_r, {3'(j), 3'(j + 2)});
            tick();
            chk("fill_gap_valid", res_valid, 0);
            if (j == 0) chk("fill_ready_back", cmd_ready, 1);
            tick();
        end
        chk("fill_end_busy", busy, 0);
        res_ready = 1'b0;

        // simultaneous push and pop at count 2
        drive(5'd10, 1'b0, 1'b0, 3'd1, 3'd1);
        tick();
        drive(5'd11, 1'b0, 1'b0, 3'd2, 3'd2);
        tick();
        drive(5'd12, 1'b0, 1'b0, 3'd3, 3'd3);
        tick();
        cmd_valid = 1'b0;
        chk("pp_count_before", dut.u_fifo.count, 2);
        chk("pp_first_opcode", res_opcode, 5'd10);
        res_ready = 1'b1;
        drive(5'd13, 1'b0, 1'b0, 3'd4, 3'd4);
        tick();
        cmd_valid = 1'b0;
        chk("pp_count_after", dut.u_fifo.count, 2);
        chk("pp_opocode", opocode, 5'd11);
        for (int j = 0; j < 3; j++) begin
            tick();
            chk("pp_res_valid", res_valid, 1);
            chk("pp_res_opcode", res_opcode, 5'(11 + j));
            tick();
        end
        chk("pp_end_busy", busy, 0);
        res_ready = 1'b0;

        // reset while in EXEC with 3 entries queued
        for (int k = 0; k < 4; k++) begin
            drive(5'(16 + k), 1'b1, 1'b0, 3'd5, 3'd6);
            tick();
        end
        res_ready = 1'b1;
        drive(5'd20, 1'b1, 1'b0, 3'd5, 3'd6);
        tick();
        cmd_valid = 1'b0;
        chk("rmid_exec_valid", res_valid, 0);
        chk("rmid_exec_opocode", opocode, 5'd17);
        chk("rmid_count", dut.u_fifo.count, 3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rmid_valid", res_valid, 0);
        chk("rmid_busy", busy, 0);
        chk("rmid_cmd_ready", cmd_ready, 1);
        chk("rmid_opocode", opocode, 0);
        chk("rmid_ops", {a, b, c, d}, 0);
        chk("rmid_res_r", res_r, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rmid_no_stale", res_valid, 0);
        end
        res_ready = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
